loop_sequencer: RTL and testbench
=================================

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 Parameter N, default 10: iterations per run; SHALL be >= 2.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on addFin and fin; SHALL be >= 2.
REQ-003 Parameter TIMEOUT, default 255: cycle limit per handshake phase, used only with the watchdog.
REQ-004 Port clk, input, 1: single clock; all state SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: synchronous run request, sampled only in IDLE.
REQ-007 Port abort, input, 1: synchronous early-stop request.
REQ-008 Port addReq, output, 1: registered 4-phase request to the downstream counter.
REQ-009 Port addFin, input, 1: asynchronous 4-phase acknowledge from the counter.
REQ-010 Port fin, input, 1: asynchronous terminal flag from the counter.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port done, output, 1: one-cycle pulse at the end of a run.
REQ-013 Port iterCnt, output, $clog2(N+1): completed handshakes in the current or last run.
REQ-014 Port err, output, 1: sticky watchdog error.

Function
REQ-015 addFin and fin SHALL each pass through their own SYNC_STAGES-flop synchronizer before use (ackS, finS).
REQ-016 The state machine SHALL have states IDLE, REQ, REL and DONE, plus ERR when the watchdog is built.
REQ-017 IDLE with start=1: next state REQ, addReq=1 from the following cycle, iterCnt cleared to 0.
REQ-018 In REQ, addReq SHALL stay 1 until ackS=1; then next state REL, addReq=0, iterCnt+1.
REQ-019 In REL, addReq SHALL stay 0 until ackS=0; then next state DONE if finS=1, iterCnt==N or abort is latched, otherwise REQ.
REQ-020 addReq SHALL never fall before ackS rises and SHALL never rise before ackS falls: strict 4-phase.
REQ-021 abort SHALL be latched in any non-IDLE state; the handshake in flight SHALL complete before DONE is entered.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE; iterCnt SHALL hold until the next start.
REQ-023 start while busy=1 SHALL be ignored; abort in IDLE SHALL be ignored.
REQ-024 If finS and iterCnt==N occur together, the sequencer SHALL exit normally to DONE once (no double done).
REQ-025 iterCnt SHALL saturate at N and SHALL never wrap.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: state IDLE, addReq=0, busy=0, done=0, iterCnt=0, err=0, abort latch clear, synchronizer flops 0.
REQ-027 Reset mid-handshake SHALL drop addReq immediately; after release the first run SHALL wait in REQ for ackS=1 as normal.

Configuration
REQ-028 Macro LOOP_SEQUENCER_WATCHDOG_EN defined: a counter runs in REQ and REL and clears on every state change.
REQ-029 With the macro defined, when that counter reaches TIMEOUT the next state SHALL be ERR: addReq=0, err=1, busy=1; only start or reset SHALL leave ERR (to IDLE, err cleared).
REQ-030 Macro undefined: no watchdog logic and no ERR state; err SHALL be tied to 0.

Structure
REQ-031 Package loop_sequencer_pkg SHALL hold the state typedef and the iterCnt width function.
REQ-032 The synchronizer SHALL be one sub-module, bit_sync (parameter STAGES), instantiated twice.

Verification
REQ-033 N=4, ideal counter model with 3-cycle ack latency, start pulse -> 4 full handshakes, iterCnt=4, done pulses once, busy then falls.
REQ-034 Counter model asserts fin after handshake 2 with N=10 -> DONE after handshake 2 completes, iterCnt=2.
REQ-035 abort pulsed while addReq=1 -> addReq held until ack, ack release observed, then done pulses, iterCnt=1.
REQ-036 rst_n pulsed low mid-REQ -> addReq=0 within the same cycle, all outputs at reset values; a new start runs cleanly.
REQ-037 Watchdog built, TIMEOUT=20, ack never returned -> ERR after 20 cycles, addReq=0, err=1; start returns to IDLE with err=0.
REQ-038 start held high for 50 cycles during a run -> exactly one run, one done pulse.

Source files
------------

// File: rtl/loop_sequencer_pkg.sv
// Shared types and helpers for the loop sequencer.
// LOOP_SEQUENCER_WATCHDOG_EN adds the StErr state.
package loop_sequencer_pkg;

`ifdef LOOP_SEQUENCER_WATCHDOG_EN
    typedef enum logic [2:0] {StIdle, StReq, StRel, StDone, StErr} state_e;
`else
    typedef enum logic [1:0] {StIdle, StReq, StRel, StDone} state_e;
`endif

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for one asynchronous level input.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/loop_sequencer.sv
// Drives N 4-phase handshakes to a downstream counter per start request.
// Define LOOP_SEQUENCER_WATCHDOG_EN to build the per-phase timeout and ERR state.
module loop_sequencer
    import loop_sequencer_pkg::*;
#(
    parameter int unsigned N           = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      addReq,
    input  logic                      addFin,
    input  logic                      fin,
    output logic                      busy,
    output logic                      done,
    output logic [cnt_width(N)-1:0]   iterCnt,
    output logic                      err
);

    localparam int unsigned CntW = cnt_width(N);
    localparam logic [CntW-1:0] NMax = CntW'(N);

    state_e          state_q, state_d;
    logic            add_req_q, add_req_d;
    logic [CntW-1:0] iter_cnt_q, iter_cnt_d;
    logic            abort_q, abort_d;
    logic            ack_s;
    logic            fin_s;

    bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (addFin),
        .q     (ack_s)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_fin_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (fin),
        .q     (fin_s)
    );

`ifdef LOOP_SEQUENCER_WATCHDOG_EN
    localparam int unsigned WdW = cnt_width(TIMEOUT);
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        add_req_d  = add_req_q;
        iter_cnt_d = iter_cnt_q;
        abort_d    = abort_q;

        unique case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                if (start) begin
                    state_d    = StReq;
                    add_req_d  = 1'b1;
                    iter_cnt_d = '0;
                end
            end
            StReq: begin
                if (abort) abort_d = 1'b1;
                if (ack_s) begin
                    state_d    = StRel;
                    add_req_d  = 1'b0;
                    iter_cnt_d = (iter_cnt_q == NMax) ? iter_cnt_q : iter_cnt_q + 1'b1;
                end
            end
            StRel: begin
                if (abort) abort_d = 1'b1;
                // Only leave once the counter has released its ack.
                if (!ack_s) begin
                    if (fin_s || (iter_cnt_q == NMax) || abort_d) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StReq;
                        add_req_d = 1'b1;
                    end
                end
            end
            StDone: begin
                abort_d = 1'b0;
                state_d = StIdle;
            end
`ifdef LOOP_SEQUENCER_WATCHDOG_EN
            StErr: begin
                abort_d   = 1'b0;
                add_req_d = 1'b0;
                if (start) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase

`ifdef LOOP_SEQUENCER_WATCHDOG_EN
        // Counts cycles spent in the current handshake phase.
        wd_cnt_d = '0;
        if ((state_q == StReq || state_q == StRel) && state_d == state_q) begin
            if (wd_cnt_q == WdMax) begin
                state_d   = StErr;
                add_req_d = 1'b0;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            add_req_q  <= 1'b0;
            iter_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            add_req_q  <= add_req_d;
            iter_cnt_q <= iter_cnt_d;
            abort_q    <= abort_d;
        end
    end

`ifdef LOOP_SEQUENCER_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign err = (state_q == StErr);
`else
    assign err = 1'b0;
`endif

    assign addReq  = add_req_q;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign iterCnt = iter_cnt_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer with a 4-phase counter model.
module tb_loop_sequencer;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       addReq;
    logic       addFin;
    logic       fin;
    logic       busy;
    logic       done;
    logic [2:0] iterCnt;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Counter-model controls, written only by the main sequence.
    bit ack_en;
    bit model_clr;
    bit mon_en;
    int lat_cfg;
    int fin_at;

    loop_sequencer #(
        .N           (N),
        .SYNC_STAGES (2),
        .TIMEOUT     (20)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .addReq  (addReq),
        .addFin  (addFin),
        .fin     (fin),
        .busy    (busy),
        .done    (done),
        .iterCnt (iterCnt),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counter model: mirrors addReq onto addFin after lat_cfg cycles.
    initial begin
        int lat;
        int hs;
        addFin = 1'b0;
        fin    = 1'b0;
        lat    = 0;
        hs     = 0;
        forever begin
            @(negedge clk);
            if (model_clr) begin
                addFin = 1'b0;
                fin    = 1'b0;
                lat    = 0;
                hs     = 0;
            end else if (ack_en && (addReq !== addFin)) begin
                lat++;
                if (lat >= lat_cfg) begin
                    lat    = 0;
                    addFin = addReq;
                    if (addFin) begin
                        hs++;
                        if (fin_at != 0 && hs == fin_at) fin = 1'b1;
                    end
                end
            end else begin
                lat = 0;
            end
        end
    end

    // 4-phase protocol monitor on addReq edges.
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (addReq && !prev_req) chk("rise_after_ack_low", 32'(addFin), 32'd0);
                if (!addReq && prev_req) chk("fall_after_ack_high", 32'(addFin), 32'd1);
            end
            prev_req = addReq;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic clear_model();
        model_clr = 1'b1;
        repeat (2) @(negedge clk);
        model_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, inout int dones, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (dones > 0 && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int dones;
        int cnt;
        bit to;

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ack_en    = 1'b1;
        model_clr = 1'b1;
        mon_en    = 1'b1;
        lat_cfg   = 3;
        fin_at    = 0;
        repeat (3) @(negedge clk);
        chk("rst_addReq", 32'(addReq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_iterCnt", 32'(iterCnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n     = 1'b1;
        model_clr = 1'b0;
        @(negedge clk);

        // Full run of N handshakes.
        clear_model();
        pulse_start();
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_addReq", 32'(addReq), 32'd1);
        chk("run_iter0", 32'(iterCnt), 32'd0);
        dones = 0;
        wait_done(300, dones, to);
        chk("run_timeout", 32'(to), 32'd0);
        chk("run_dones", 32'(dones), 32'd1);
        chk("run_iterCnt", 32'(iterCnt), 32'd4);
        chk("run_idle_addReq", 32'(addReq), 32'd0);
        repeat (5) @(negedge clk);
        chk("run_hold_busy", 32'(busy), 32'd0);
        chk("run_hold_iter", 32'(iterCnt), 32'd4);

        // abort in IDLE is ignored by the next run.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        clear_model();
        pulse_start();
        dones = 0;
        wait_done(300, dones, to);
        chk("idle_abort_timeout", 32'(to), 32'd0);
        chk("idle_abort_iter", 32'(iterCnt), 32'd4);

        // fin after handshake 2.
        fin_at = 2;
        clear_model();
        pulse_start();
        dones = 0;
        wait_done(300, dones, to);
        chk("fin2_timeout", 32'(to), 32'd0);
        chk("fin2_dones", 32'(dones), 32'd1);
        chk("fin2_iter", 32'(iterCnt), 32'd2);

        // fin coincides with the last handshake.
        fin_at = 4;
        clear_model();
        pulse_start();
        dones = 0;
        wait_done(300, dones, to);
        repeat (5) @(negedge clk) if (done) dones++;
        chk("finN_dones", 32'(dones), 32'd1);
        chk("finN_iter", 32'(iterCnt), 32'd4);
        fin_at = 0;

        // abort while addReq is high: handshake completes first.
        clear_model();
        pulse_start();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_req_held", 32'(addReq), 32'd1);
        chk("abort_busy", 32'(busy), 32'd1);
        dones = 0;
        wait_done(300, dones, to);
        chk("abort_timeout", 32'(to), 32'd0);
        chk("abort_dones", 32'(dones), 32'd1);
        chk("abort_iter", 32'(iterCnt), 32'd1);
        chk("abort_ack_released", 32'(addFin), 32'd0);

        // start held for 50 cycles inside one long run.
        lat_cfg = 6;
        clear_model();
        dones = 0;
        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        chk("hold_busy_mid", 32'(busy), 32'd1);
        wait_done(400, dones, to);
        chk("hold_timeout", 32'(to), 32'd0);
        repeat (20) @(negedge clk) if (done) dones++;
        chk("hold_dones", 32'(dones), 32'd1);
        chk("hold_iter", 32'(iterCnt), 32'd4);
        chk("hold_no_rerun", 32'(busy), 32'd0);
        lat_cfg = 3;

        // Reset mid-REQ.
        clear_model();
        pulse_start();
        @(negedge clk);
        mon_en    = 1'b0;
        model_clr = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("mid_rst_addReq", 32'(addReq), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_iter", 32'(iterCnt), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        model_clr = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        pulse_start();
        dones = 0;
        wait_done(300, dones, to);
        chk("post_rst_timeout", 32'(to), 32'd0);
        chk("post_rst_dones", 32'(dones), 32'd1);
        chk("post_rst_iter", 32'(iterCnt), 32'd4);

        // Counter never acknowledges.
        mon_en = 1'b0;
        ack_en = 1'b0;
        clear_model();
`ifdef LOOP_SEQUENCER_WATCHDOG_EN
        pulse_start();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (err) break;
            if (busy && addReq) cnt++;
            @(negedge clk);
        end
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_req_cycles", 32'(cnt), 32'd20);
        chk("wd_addReq", 32'(addReq), 32'd0);
        chk("wd_busy", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        chk("wd_err_sticky", 32'(err), 32'd1);
        pulse_start();
        chk("wd_clear_err", 32'(err), 32'd0);
        chk("wd_clear_busy", 32'(busy), 32'd0);
`else
        pulse_start();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (err) cnt++;
        end
        chk("nowd_err_low", 32'(cnt), 32'd0);
        chk("nowd_addReq", 32'(addReq), 32'd1);
        chk("nowd_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("nowd_recover", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
